// File: rtl/demux1x8_reg_if.sv
// Producer/consumer bundle for the registered 1-to-8 demultiplexer.
interface demux1x8_reg_if #(
    parameter int DATA_WIDTH = 1
);
    logic [DATA_WIDTH-1:0]   in_data;
    logic [2:0]              in_select;
    logic                    in_valid;
    logic                    in_ready;
    logic [8*DATA_WIDTH-1:0] out_data;
    logic [7:0]              out_valid;
    logic [7:0]              out_ready;
    logic [3:0]              occupancy;

    modport master (
        output in_data, in_select, in_valid, out_ready,
        input  in_ready, out_data, out_valid, occupancy
    );

    modport slave (
        input  in_data, in_select, in_valid, out_ready,
        output in_ready, out_data, out_valid, occupancy
    );
endinterface

// File: rtl/demux1x8_reg.sv
// Registered 1-to-8 demultiplexer with independent valid/ready per channel.
module demux1x8_reg #(
    parameter int DATA_WIDTH = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    demux1x8_reg_if.slave  bus
);
    logic [7:0]            full;
    logic [7:0]            full_nxt;
    logic [3:0]            occ_nxt;
    logic [3:0]            occ_q;
    logic                  accept;
    logic [DATA_WIDTH-1:0] data [8];

    // Only the addressed channel gates acceptance; a full channel takes a
    // new word only when its old one is consumed on the same edge.
    always_comb begin
        bus.in_ready = reset_n &&
                       (!full[bus.in_select] || bus.out_ready[bus.in_select]);
        accept = bus.in_valid && bus.in_ready;
        full_nxt = full & ~bus.out_ready;
        if (accept) begin
            full_nxt[bus.in_select] = 1'b1;
        end
        occ_nxt = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            occ_nxt = occ_nxt + {3'b000, full_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full  <= '0;
            occ_q <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                data[i] <= '0;
            end
        end else begin
            full  <= full_nxt;
            occ_q <= occ_nxt;
            if (accept) begin
                data[bus.in_select] <= bus.in_data;
            end
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            bus.out_data[i*DATA_WIDTH +: DATA_WIDTH] = data[i];
        end
    end

    assign bus.out_valid = full;
    assign bus.occupancy = occ_q;
endmodule
